// File: rtl/skid_pkg.sv
// Shared constants and sizing helpers for the skid_pipe register-slice chain.
package skid_pkg;

  localparam int SKID_MAX_STAGES = 16;

  function automatic int skid_occ_w(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

  // Port width for occ; a zero-stage pipe still needs a one-bit port.
  function automatic int skid_occ_pw(input int stages);
    return (skid_occ_w(stages) < 1) ? 1 : skid_occ_w(stages);
  endfunction

endpackage

// File: rtl/skid_stage.sv
// One full register slice: registered valid/data forward, registered ready backward,
// with a one-word skid buffer absorbing the word in flight when downstream stalls.
module skid_stage #(
  parameter int L = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         valid_f,
  output logic         ready_f,
  input  logic [L-1:0] data_f,
  output logic         valid_b,
  input  logic         ready_b,
  output logic [L-1:0] data_b
);

  logic         m_v_q, m_v_d;
  logic         s_v_q, s_v_d;
  logic [L-1:0] m_d_q, m_d_d;
  logic [L-1:0] s_d_q, s_d_d;
  logic         load;
  logic         acc;

  assign ready_f = !s_v_q;
  assign valid_b = m_v_q;
  assign data_b  = m_d_q;

  // Main register may take a new word whenever it is empty or being drained.
  assign load = ready_b | !m_v_q;
  assign acc  = valid_f & !s_v_q;

  always_comb begin
    m_v_d = m_v_q;
    s_v_d = s_v_q;
    m_d_d = m_d_q;
    s_d_d = s_d_q;
    if (flush) begin
      m_v_d = 1'b0;
      s_v_d = 1'b0;
    end else if (load) begin
      m_v_d = s_v_q | acc;
      if (s_v_q) begin
        m_d_d = s_d_q;
      end else if (acc) begin
        m_d_d = data_f;
      end
      s_v_d = 1'b0;
    end else if (acc) begin
      s_v_d = 1'b1;
      s_d_d = data_f;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_v_q <= 1'b0;
      s_v_q <= 1'b0;
      m_d_q <= '0;
      s_d_q <= '0;
    end else begin
      m_v_q <= m_v_d;
      s_v_q <= s_v_d;
      m_d_q <= m_d_d;
      s_d_q <= s_d_d;
    end
  end

endmodule

// File: rtl/skid_pipe.sv
// Chain of STAGES full register slices with synchronous flush.
// Optional occupancy counter and port occ compiled in with SKID_PIPE_OCC_EN.
module skid_pipe
  import skid_pkg::*;
#(
  parameter int L      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         valid_f,
  output logic         ready_f,
  input  logic [L-1:0] data_f,
  output logic         valid_b,
  input  logic         ready_b,
  output logic [L-1:0] data_b
`ifdef SKID_PIPE_OCC_EN
  ,
  output logic [skid_occ_pw(STAGES)-1:0] occ
`endif
);

  if (STAGES == 0) begin : g_pass
    logic unused_ctl;

    assign ready_f    = ready_b;
    assign valid_b    = valid_f;
    assign data_b     = data_f;
    assign unused_ctl = clk ^ rst ^ flush;
`ifdef SKID_PIPE_OCC_EN
    assign occ = '0;
`endif
  end else begin : g_chain
    logic [STAGES:0] v;
    logic [STAGES:0] r;
    logic [L-1:0]    d [STAGES+1];

    assign v[0]       = valid_f;
    assign d[0]       = data_f;
    assign ready_f    = r[0];
    assign valid_b    = v[STAGES];
    assign data_b     = d[STAGES];
    assign r[STAGES]  = ready_b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      skid_stage #(
        .L(L)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .valid_f (v[k]),
        .ready_f (r[k]),
        .data_f  (d[k]),
        .valid_b (v[k+1]),
        .ready_b (r[k+1]),
        .data_b  (d[k+1])
      );
    end

`ifdef SKID_PIPE_OCC_EN
    localparam int OW = skid_occ_pw(STAGES);
    logic [OW-1:0] occ_q, occ_d;
    logic          in_xfer;
    logic          out_xfer;

    assign in_xfer  = valid_f & ready_f;
    assign out_xfer = valid_b & ready_b;
    assign occ      = occ_q;

    // Accept and deliver on the same edge cancel; flush drops everything held.
    always_comb begin
      occ_d = occ_q;
      if (flush) begin
        occ_d = '0;
      end else if (in_xfer && !out_xfer) begin
        occ_d = occ_q + OW'(1);
      end else if (!in_xfer && out_xfer) begin
        occ_d = occ_q - OW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        occ_q <= '0;
      end else begin
        occ_q <= occ_d;
      end
    end
`endif
  end

endmodule
